// File: rtl/fetch_unit.sv
// Instruction fetch: PC, IR capture, stall hold, branch squash, halt drain; one byte per cycle, IR one edge after PC.
// Stall freezes PC/IR until the IR is consumed; optional FETCH_COUNT_EN adds a saturating accepted-fetch counter.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  imem_addr,
  input  logic [7:0]  imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  input  logic        halt_req,
  output logic [7:0]  ir,
  output logic        ir_valid,
  output logic [7:0]  ir_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] pc;

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      ir       <= 8'h00;
      ir_valid <= 1'b0;
      ir_pc    <= 8'h00;
      halted   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          // Halt outranks a simultaneous branch so the PC stays where it was.
          if (halt_req) begin
            if (!stall) begin
              ir_valid <= 1'b0;
              halted   <= 1'b1;
              state    <= HALT;
            end else begin
              state <= DRAIN;
            end
          end else if (branch_taken) begin
            pc       <= branch_target;
            ir_valid <= 1'b0;
          end else if (!stall) begin
            ir       <= imem_data;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            pc       <= pc + 8'd1;
          end
        end
        DRAIN: begin
          // Wait for decode to take the pending IR before going quiet.
          if (!stall) begin
            ir_valid <= 1'b0;
            halted   <= 1'b1;
            state    <= HALT;
          end
        end
        HALT: begin
          ir_valid <= 1'b0;
          halted   <= 1'b1;
        end
        default: begin
          state    <= HALT;
          ir_valid <= 1'b0;
          halted   <= 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  logic        fetch_fire;
  logic [15:0] count_q;

  assign fetch_fire = (state == RUN) && !halt_req && !branch_taken && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 16'h0000;
    end else if (fetch_fire && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule
